// File: rtl/alu_pkg.sv
// Shared definitions for the binary32 ALU: opcodes, format constants,
// the unpacked-float view and operand classification helpers.
package alu_pkg;

    localparam logic [2:0]  OP_FADD  = 3'b000;
    localparam logic [2:0]  OP_FSUB  = 3'b001;
    localparam logic [2:0]  OP_FMUL  = 3'b010;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
    } ufloat_t;

    // Exponent field of zero covers both true zeros and flushed subnormals.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Hidden bit is always set; callers handle zero/special operands separately.
    function automatic ufloat_t unpack(input logic [31:0] x);
        ufloat_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.mant = {1'b1, x[22:0]};
        return u;
    endfunction

    function automatic logic [4:0] clz27(input logic [26:0] x);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised 24-bit mantissa plus guard/round/
// sticky, then pack to binary32 with overflow to Inf and flush-to-zero.
module fp_round_pack
    import alu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [26:0]       mantissa,
    output logic [31:0]       result
);

    logic              round_up;
    logic [24:0]       rounded;
    logic signed [9:0] exp_final;
    logic [22:0]       frac;

    // Round first at full precision, then decide overflow / underflow on the final exponent.
    always_comb begin
        round_up  = mantissa[2] & (mantissa[1] | mantissa[0] | mantissa[3]);
        rounded   = {1'b0, mantissa[26:3]} + {24'd0, round_up};
        exp_final = exponent + $signed({9'd0, rounded[24]});
        frac      = rounded[24] ? rounded[23:1] : rounded[22:0];
        if (exp_final >= 10'sd255)
            result = {sign, 8'hFF, 23'd0};
        else if (exp_final <= 10'sd0)
            result = {sign, FP_ZERO[30:0]};
        else
            result = {sign, exp_final[7:0], frac};
    end

endmodule

// File: rtl/alu.sv
// Binary32 floating-point ALU: FADD / FSUB / FMUL with a single registered
// result. Both datapaths are combinational and share one rounding stage.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  OPERATIONCODE,
    output logic [31:0] O
);

    ufloat_t           ua, ub, hi, lo;
    logic              a_is_hi, eff_sub;
    logic [7:0]        exp_diff;
    logic [49:0]       lo_ext;
    logic [26:0]       lo_al;
    logic [27:0]       add_sum;
    logic [4:0]        add_lzc;
    logic [26:0]       add_mant;
    logic signed [9:0] add_exp;

    logic [47:0]       mul_prod;
    logic [26:0]       mul_mant;
    logic signed [9:0] mul_exp;
    logic              mul_sign;

    logic              rp_sign;
    logic signed [9:0] rp_exp;
    logic [26:0]       rp_mant;
    logic [31:0]       rp_result;

    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [31:0]       next_o;

    // Add/sub datapath: order by magnitude, align with sticky, add, normalise.
    always_comb begin
        ua      = unpack(A);
        ub      = unpack(B);
        ub.sign = B[31] ^ (OPERATIONCODE == OP_FSUB);
        a_is_hi = A[30:0] >= B[30:0];
        hi      = a_is_hi ? ua : ub;
        lo      = a_is_hi ? ub : ua;
        eff_sub = hi.sign ^ lo.sign;

        exp_diff = hi.exp - lo.exp;
        lo_ext   = {lo.mant, 26'd0} >> exp_diff;
        // Beyond 25 places the small operand only contributes stickiness.
        if (exp_diff > 8'd25)
            lo_al = 27'd1;
        else
            lo_al = {lo_ext[49:24], |lo_ext[23:0]};

        if (eff_sub)
            add_sum = {1'b0, hi.mant, 3'b000} - {1'b0, lo_al};
        else
            add_sum = {1'b0, hi.mant, 3'b000} + {1'b0, lo_al};

        add_lzc = clz27(add_sum[26:0]);
        if (add_sum[27]) begin
            add_mant = {add_sum[27:2], add_sum[1] | add_sum[0]};
            add_exp  = $signed({2'b00, hi.exp}) + 10'sd1;
        end else begin
            add_mant = add_sum[26:0] << add_lzc;
            add_exp  = $signed({2'b00, hi.exp}) - $signed({5'd0, add_lzc});
        end
    end

    // Multiply datapath: full 48-bit product, 1-bit normalise, collapse tail into sticky.
    always_comb begin
        mul_prod = {24'd0, ua.mant} * {24'd0, ub.mant};
        mul_sign = A[31] ^ B[31];
        mul_exp  = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp})
                 - 10'(EXP_BIAS) + $signed({9'd0, mul_prod[47]});
        if (mul_prod[47])
            mul_mant = {mul_prod[47:22], |mul_prod[21:0]};
        else
            mul_mant = {mul_prod[46:21], |mul_prod[20:0]};
    end

    // Steer the active datapath into the shared rounder.
    always_comb begin
        if (OPERATIONCODE == OP_FMUL) begin
            rp_sign = mul_sign;
            rp_exp  = mul_exp;
            rp_mant = mul_mant;
        end else begin
            rp_sign = hi.sign;
            rp_exp  = add_exp;
            rp_mant = add_mant;
        end
    end

    fp_round_pack u_round_pack (
        .sign     (rp_sign),
        .exponent (rp_exp),
        .mantissa (rp_mant),
        .result   (rp_result)
    );

    // Special-operand handling overrides the arithmetic result.
    always_comb begin
        nan_a  = is_nan(A);
        nan_b  = is_nan(B);
        inf_a  = is_inf(A);
        inf_b  = is_inf(B);
        zero_a = is_zero(A);
        zero_b = is_zero(B);
        next_o = FP_ZERO;
        case (OPERATIONCODE)
            OP_FADD, OP_FSUB: begin
                if (nan_a || nan_b)
                    next_o = QNAN;
                else if (inf_a && inf_b)
                    next_o = (A[31] == ub.sign) ? {A[31], 8'hFF, 23'd0} : QNAN;
                else if (inf_a)
                    next_o = {A[31], 8'hFF, 23'd0};
                else if (inf_b)
                    next_o = {ub.sign, 8'hFF, 23'd0};
                else if (zero_a && zero_b)
                    next_o = {A[31] & ub.sign, 31'd0};
                else if (zero_a)
                    next_o = {ub.sign, B[30:0]};
                else if (zero_b)
                    next_o = A;
                else if (add_sum == 28'd0)
                    next_o = FP_ZERO;
                else
                    next_o = rp_result;
            end
            OP_FMUL: begin
                if (nan_a || nan_b)
                    next_o = QNAN;
                else if ((inf_a && zero_b) || (inf_b && zero_a))
                    next_o = QNAN;
                else if (inf_a || inf_b)
                    next_o = {mul_sign, 8'hFF, 23'd0};
                else if (zero_a || zero_b)
                    next_o = {mul_sign, 31'd0};
                else
                    next_o = rp_result;
            end
            default: next_o = FP_ZERO;
        endcase
    end

    // Single result register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            O <= FP_ZERO;
        else
            O <= next_o;
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the binary32 ALU. Expected results come from an
// exact-arithmetic reference model (wide integers, explicit RNE on the
// discarded remainder) and are checked by an independent monitor.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B, O;
    logic [2:0]  op;

    alu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .OPERATIONCODE (op),
        .O             (O)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    // Round an exact value mag * 2^scale to binary32 (RNE, FTZ, overflow to Inf).
    function automatic logic [31:0] round_val(input logic s, input logic [127:0] mag, input int scale);
        int           p, sh, e;
        logic [127:0] keep, rem, half;
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e = p + scale + 127;
        if (p >= 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag - (keep << sh);
            half = (sh > 0) ? (128'd1 << (sh - 1)) : 128'd0;
            if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 128'd1;
        end else begin
            keep = mag << (23 - p);
        end
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        logic         sa, sb, st;
        int           ea, eb, et, d;
        logic [127:0] ma, mb, mt, mag;
        bit           na, nb, ia, ib, za, zb;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        za = (ea == 0); zb = (eb == 0);
        ma = {104'd0, 1'b1, a[22:0]};
        mb = {104'd0, 1'b1, b[22:0]};
        if (o == 3'b010) begin
            if (na || nb) return 32'h7FC0_0000;
            if ((ia && zb) || (ib && za)) return 32'h7FC0_0000;
            if (ia || ib) return {sa ^ sb, 8'hFF, 23'd0};
            if (za || zb) return {sa ^ sb, 31'd0};
            return round_val(sa ^ sb, ma * mb, ea + eb - 300);
        end
        if (o == 3'b000 || o == 3'b001) begin
            if (o == 3'b001) sb = ~sb;
            if (na || nb) return 32'h7FC0_0000;
            if (ia && ib) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
            if (ia) return {sa, 8'hFF, 23'd0};
            if (ib) return {sb, 8'hFF, 23'd0};
            if (za && zb) return {sa & sb, 31'd0};
            if (za) return {sb, b[30:0]};
            if (zb) return a;
            if (ea < eb || (ea == eb && ma < mb)) begin
                st = sa; sa = sb; sb = st;
                et = ea; ea = eb; eb = et;
                mt = ma; ma = mb; mb = mt;
            end
            d = ea - eb;
            if (d > 100) return {sa, ea[7:0], ma[22:0]};
            ma  = ma << d;
            mag = (sa == sb) ? (ma + mb) : (ma - mb);
            if (mag == 0) return 32'h0000_0000;
            return round_val(sa, mag, eb - 150);
        end
        return 32'h0000_0000;
    endfunction

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            case ($urandom_range(0, 8))
                0: return 32'h0000_0000;
                1: return 32'h8000_0000;
                2: return 32'h7F80_0000;
                3: return 32'hFF80_0000;
                4: return 32'h7FC0_0000;
                5: return 32'h7F81_2345;
                6: return 32'h0001_2345;
                7: return 32'h8040_0000;
                default: return 32'h3F80_0000;
            endcase
        end
        if (r < 5) return $urandom;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o, input string tag);
        @(negedge clk);
        A  = a;
        B  = b;
        op = o;
        exp_q.push_back(ref_model(a, b, o));
        name_q.push_back($sformatf("%s A=%08h B=%08h op=%0d", tag, a, b, o));
    endtask

    // Monitor: every sampled operation produces O one edge later.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (O !== mon_exp) begin
                errors++;
                $display("FAIL %s: got %08h expected %08h", mon_name, O, mon_exp);
            end
        end
    end

    task automatic direct_check(input string tag, input logic [31:0] want);
        checks++;
        if (O !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, O, want);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;
        int          r, eb;

        rst_n = 1'b0;
        A = 32'h0; B = 32'h0; op = 3'b000;
        repeat (2) @(posedge clk);
        #1 direct_check("reset_value", 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'hB725A347, 32'h47DA4189, 3'b000, "fadd_absorb");
        issue(32'h34AA724D, 32'h29D5DF3B, 3'b000, "fadd_rne_small");
        issue(32'hA64BAB24, 32'h9F545195, 3'b000, "fadd_neg1");
        issue(32'hD8817676, 32'hE386DF4E, 3'b000, "fadd_neg2");
        issue(32'h3F800000, 32'hBF800000, 3'b000, "fadd_cancel");
        issue(32'h40400000, 32'h3F800000, 3'b001, "fsub_3m1");
        issue(32'h40000000, 32'h40400000, 3'b010, "fmul_2x3");
        issue(32'h7F800000, 32'hFF800000, 3'b000, "inf_minus_inf");
        issue(32'h7F000000, 32'h7F000000, 3'b010, "fmul_overflow");
        issue(32'h40000000, 32'h40400000, 3'b111, "reserved_op");
        issue(32'h7F800000, 32'h00000000, 3'b010, "inf_times_zero");
        issue(32'h00800000, 32'h00800000, 3'b010, "fmul_underflow");
        issue(32'hC0A00000, 32'h00000000, 3'b000, "fadd_plus_zero");
        issue(32'h3F800000, 32'h33800000, 3'b000, "fadd_tie_even");
        issue(32'h3F800001, 32'h33800000, 3'b000, "fadd_tie_odd");
        issue(32'h3F800000, 32'h3F800000, 3'b001, "fsub_cancel");
        issue(32'h7FFFFFFF, 32'h3F800000, 3'b010, "nan_in");

        for (int n = 0; n < 3000; n++) begin
            a = pick_operand();
            if ($urandom_range(0, 3) == 0) begin
                eb = int'(a[30:23]) + $urandom_range(0, 6) - 3;
                if (eb < 1)   eb = 1;
                if (eb > 254) eb = 254;
                b = {1'($urandom_range(0, 1)), eb[7:0], 23'($urandom)};
            end else begin
                b = pick_operand();
            end
            r = $urandom_range(0, 9);
            if (r < 3)      o = 3'b000;
            else if (r < 6) o = 3'b001;
            else if (r < 9) o = 3'b010;
            else            o = 3'($urandom_range(3, 7));
            issue(a, b, o, "random");
        end

        issue(32'h40000000, 32'h40400000, 3'b010, "pre_reset");
        @(negedge clk);
        #2 direct_check("before_reset", 32'h40C0_0000);
        rst_n = 1'b0;
        #1 direct_check("async_reset", 32'h0000_0000);
        @(posedge clk);
        #1 direct_check("reset_hold", 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h3FC00000, 32'h3FC00000, 3'b000, "after_reset");
        issue(32'hBF800000, 32'h40000000, 3'b010, "after_reset_mul");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
